// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one 8N1 UART transmitter between pChannels byte-stream
//   requesters. Messages are granted whole (delimited by iReqLast), so bytes from different
//   channels never interleave. A grant is cut after pMaxBytes payload bytes; the remainder of
//   the message resumes on a later grant, after the other valid channels have been served.
//
// Build option:
//   UART_TX_TAG_EN  when defined, every grant (including a resumed one) starts with a tag byte
//                   8'hA0 | owner[3:0], sent without a requester ack and not counted in pMaxBytes.
//
// Ports:
//   iClock, iReset  clock and synchronous active-high reset
//   iReqValid[i]    channel i presents a byte on iReqData[8i+7:8i]
//   iReqLast[i]     that byte ends its message
//   oReqAck[i]      1-cycle pulse, byte of channel i consumed
//   oGrant          one-hot current owner, 0 when idle
//   oTxData/oTxSend byte and 1-cycle send pulse to the transmitter
//   iTxReady        transmitter ready
//   oBusy           a grant is held
//   All outputs are registered.
module uart_tx_arbiter #(
  parameter int unsigned pChannels = 4,
  parameter int unsigned pMaxBytes = 64
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic [pChannels-1:0]   iReqValid,
  input  logic [8*pChannels-1:0] iReqData,
  input  logic [pChannels-1:0]   iReqLast,
  output logic [pChannels-1:0]   oReqAck,
  output logic [pChannels-1:0]   oGrant,
  output logic [7:0]             oTxData,
  output logic                   oTxSend,
  input  logic                   iTxReady,
  output logic                   oBusy
);

  localparam int unsigned PtrW = (pChannels > 1) ? $clog2(pChannels) : 1;
  localparam int unsigned CntW = $clog2(pMaxBytes + 1);

  typedef enum logic [2:0] {StIdle, StArb, StHeader, StData, StRelease} state_e;

  state_e               state_q, state_d;
  // Round-robin pointer; while a grant is held it is also the owner's index.
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [pChannels-1:0] grant_q, grant_d;
  logic [pChannels-1:0] ack_q, ack_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_send_q, tx_send_d;
  logic                 busy_q, busy_d;

  logic [PtrW-1:0]      winner;
  logic [PtrW-1:0]      idx;
  logic                 found;
  logic                 cur_valid;
  logic                 cur_last;
  logic [7:0]           cur_data;
  logic                 last_slot;

  // A send last cycle blocks this cycle: the transmitter has not dropped iTxReady yet and the
  // requester has not presented its next byte yet.
  logic                 holdoff;
  assign holdoff = tx_send_q;

  // First valid channel at ptr+1, ptr+2, ... (mod pChannels).
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= pChannels; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % pChannels);
      if (!found && iReqValid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign cur_valid = iReqValid[ptr_q];
  assign cur_last  = iReqLast[ptr_q];
  assign cur_data  = iReqData[8*ptr_q +: 8];
  assign last_slot = ((count_q + 1'b1) == CntW'(pMaxBytes));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    ack_d     = '0;
    case (state_q)
      StIdle: begin
        if (|iReqValid) state_d = StArb;
      end
      StArb: begin
        if (found) begin
          grant_d = pChannels'(1) << winner;
          ptr_d   = winner;
          count_d = '0;
          busy_d  = 1'b1;
`ifdef UART_TX_TAG_EN
          state_d = StHeader;
`else
          state_d = StData;
`endif
        end else begin
          state_d = StIdle;
        end
      end
`ifdef UART_TX_TAG_EN
      StHeader: begin
        if (iTxReady && !holdoff) begin
          tx_data_d = 8'hA0 | {4'h0, 4'(ptr_q)};
          tx_send_d = 1'b1;
          state_d   = StData;
        end
      end
`endif
      StData: begin
        // A stalled requester simply holds the grant; there is no timeout.
        if (iTxReady && !holdoff && cur_valid) begin
          tx_data_d = cur_data;
          tx_send_d = 1'b1;
          ack_d     = pChannels'(1) << ptr_q;
          count_d   = count_q + 1'b1;
          if (cur_last || last_slot) state_d = StRelease;
        end
      end
      StRelease: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = (|iReqValid) ? StArb : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q   <= StIdle;
      ptr_q     <= PtrW'(pChannels - 1);
      count_q   <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      busy_q    <= busy_d;
    end
  end

  assign oReqAck = ack_q;
  assign oGrant  = grant_q;
  assign oTxData = tx_data_q;
  assign oTxSend = tx_send_q;
  assign oBusy   = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester queues and a transmitter model drive the DUT; a
// message-level round-robin model predicts the exact byte stream and owners.
module tb_uart_tx_arbiter;

  localparam int NCH  = 8;
  localparam int MAXB = 4;

  logic             iClock = 1'b0;
  logic             iReset = 1'b1;
  logic [NCH-1:0]   iReqValid = '0;
  logic [8*NCH-1:0] iReqData = '0;
  logic [NCH-1:0]   iReqLast = '0;
  logic [NCH-1:0]   oReqAck;
  logic [NCH-1:0]   oGrant;
  logic [7:0]       oTxData;
  logic             oTxSend;
  logic             iTxReady = 1'b1;
  logic             oBusy;

  uart_tx_arbiter #(.pChannels(NCH), .pMaxBytes(MAXB)) dut (
    .iClock(iClock), .iReset(iReset), .iReqValid(iReqValid), .iReqData(iReqData),
    .iReqLast(iReqLast), .oReqAck(oReqAck), .oGrant(oGrant), .oTxData(oTxData),
    .oTxSend(oTxSend), .iTxReady(iTxReady), .oBusy(oBusy)
  );

  always #5 iClock = ~iClock;

  // Requester-side byte queues ({last, data}) and the model's copy of the same traffic.
  logic [8:0] rq [NCH][$];
  logic [8:0] mq [NCH][$];
  // Expected transmitter stream.
  int         exp_ch[$];
  logic [7:0] exp_data[$];
  bit         exp_tag[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int mptr = NCH - 1;
  int tx_wait = 0;
  bit tied = 0;
  bit prev_send = 0;
  bit seg_valid = 0;
  int last_send_cyc = 0;
  int first_send = -1;
  int ack_cnt[NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [NCH-1:0] onehot(input int c);
    logic [NCH-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic push_byte(input int ch, input logic [7:0] d, input bit last);
    rq[ch].push_back({last, d});
    mq[ch].push_back({last, d});
  endtask

  // Message-level round robin: each grant goes to the next channel after the previous owner
  // that has bytes pending, and carries up to MAXB bytes or up to the end of its message.
  task automatic build_expected();
    int found;
    int n;
    logic [8:0] w;
    forever begin
      found = -1;
      for (int k = 1; k <= NCH; k++) begin
        if (found < 0 && mq[(mptr + k) % NCH].size() > 0) found = (mptr + k) % NCH;
      end
      if (found < 0) break;
      mptr = found;
`ifdef UART_TX_TAG_EN
      exp_ch.push_back(found);
      exp_data.push_back(8'hA0 | 8'(found));
      exp_tag.push_back(1'b1);
`endif
      n = 0;
      do begin
        w = mq[found].pop_front();
        exp_ch.push_back(found);
        exp_data.push_back(w[7:0]);
        exp_tag.push_back(1'b0);
        n++;
      end while (!w[8] && n < MAXB);
    end
  endtask

  task automatic drive_req();
    for (int c = 0; c < NCH; c++) begin
      if (rq[c].size() > 0) begin
        iReqValid[c]       = 1'b1;
        iReqData[8*c +: 8] = rq[c][0][7:0];
        iReqLast[c]        = rq[c][0][8];
      end else begin
        iReqValid[c]       = 1'b0;
        iReqData[8*c +: 8] = 8'h00;
        iReqLast[c]        = 1'b0;
      end
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 0;
    for (int c = 0; c < NCH; c++) if (rq[c].size() > 0) p = 1;
    return p;
  endfunction

  // One cycle: check outputs at the falling edge, then update requesters and transmitter.
  task automatic tick();
    int ec;
    logic [7:0] ed;
    bit et;
    @(negedge iClock);
    cyc++;
    chk("ack_outside_grant", 32'(oReqAck & ~oGrant), 32'h0);
    if (oTxSend) begin
      if (first_send < 0) first_send = cyc;
      chk("send_back_to_back", 32'(prev_send), 32'h0);
      if (exp_ch.size() == 0) begin
        chk("unexpected_send", 32'(oTxData), 32'hFFFF_FFFF);
      end else begin
        ec = exp_ch.pop_front();
        ed = exp_data.pop_front();
        et = exp_tag.pop_front();
        chk("tx_data", 32'(oTxData), 32'(ed));
        chk("grant_owner", 32'(oGrant), 32'(onehot(ec)));
        chk("ack", 32'(oReqAck), et ? 32'h0 : 32'(onehot(ec)));
      end
      if (tied && seg_valid) chk("send_spacing", 32'(cyc - last_send_cyc), 32'd2);
      last_send_cyc = cyc;
      seg_valid = 1;
    end else begin
      chk("ack_without_send", 32'(oReqAck), 32'h0);
    end
    if (!oBusy) seg_valid = 0;
    prev_send = oTxSend;
    for (int c = 0; c < NCH; c++) begin
      if (oReqAck[c] && rq[c].size() > 0) begin
        void'(rq[c].pop_front());
        ack_cnt[c]++;
      end
    end
    if (oTxSend) tx_wait = $urandom_range(1, 4);
    else if (tx_wait > 0) tx_wait--;
    iTxReady = tied || (tx_wait == 0);
    drive_req();
  endtask

  task automatic run_done(input int bound);
    int n;
    n = 0;
    while ((exp_ch.size() > 0 || oBusy || pending()) && n < bound) begin
      tick();
      n++;
    end
    chk("timeout", 32'(n < bound), 32'h1);
    repeat (3) tick();
    chk("idle_busy", 32'(oBusy), 32'h0);
    chk("idle_grant", 32'(oGrant), 32'h0);
    chk("stream_drained", 32'(exp_ch.size()), 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(oReqAck), 32'h0);
    chk({tag, "_grant"}, 32'(oGrant), 32'h0);
    chk({tag, "_txdata"}, 32'(oTxData), 32'h0);
    chk({tag, "_txsend"}, 32'(oTxSend), 32'h0);
    chk({tag, "_busy"}, 32'(oBusy), 32'h0);
  endtask

  initial begin
    int load_cyc;
    int sum_other;
    for (int c = 0; c < NCH; c++) ack_cnt[c] = 0;

    // Reset state.
    iReset = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    iReset = 1'b0;
    tick();

    // ch0 sends 11,22,33; first send 3 cycles after valid.
    push_byte(0, 8'h11, 0);
    push_byte(0, 8'h22, 0);
    push_byte(0, 8'h33, 1);
    build_expected();
    drive_req();
    load_cyc = cyc;
    first_send = -1;
    run_done(500);
    chk("latency", 32'(first_send - load_cyc), 32'd3);
    chk("acks_ch0", 32'(ack_cnt[0]), 32'd3);
    sum_other = 0;
    for (int c = 1; c < NCH; c++) sum_other += ack_cnt[c];
    chk("acks_other", 32'(sum_other), 32'd0);

    // ch0..ch3 with 2-byte messages, then ch2 and ch0 together: ch0 must win.
    for (int c = 0; c < 4; c++) begin
      push_byte(c, 8'(8'h40 + 2 * c), 0);
      push_byte(c, 8'(8'h41 + 2 * c), 1);
    end
    build_expected();
    drive_req();
    run_done(500);
    push_byte(2, 8'hC2, 1);
    push_byte(0, 8'hC0, 1);
    build_expected();
    drive_req();
    run_done(500);

    // Length cap: ch1 streams 10 bytes, ch2 has 1 byte.
    for (int i = 0; i < 10; i++) push_byte(1, 8'(8'h90 + i), i == 9);
    push_byte(2, 8'h2B, 1);
    build_expected();
    drive_req();
    run_done(1000);

    // Transmitter always ready: sends within a grant exactly 2 cycles apart.
    tied = 1;
    for (int i = 0; i < 5; i++) push_byte(3, 8'(8'h30 + i), i == 4);
    for (int i = 0; i < 3; i++) push_byte(1, 8'(8'h10 + i), i == 2);
    build_expected();
    drive_req();
    run_done(1000);
    tied = 0;

    // ch5 single byte 7E (tag A5 first when tagging is built in).
    push_byte(5, 8'h7E, 1);
    build_expected();
    drive_req();
    run_done(500);

    // Reset mid-message on ch2 after the first ack.
    push_byte(2, 8'hAA, 0);
    push_byte(2, 8'hBB, 0);
    push_byte(2, 8'hCC, 1);
    build_expected();
    drive_req();
    begin
      int n;
      n = 0;
      while (rq[2].size() > 2 && n < 200) begin
        tick();
        n++;
      end
      chk("first_ack_seen", 32'(rq[2].size()), 32'd2);
    end
    iReset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    iReset = 1'b0;
    tx_wait = 0;
    iTxReady = 1'b1;
    exp_ch.delete();
    exp_data.delete();
    exp_tag.delete();
    mptr = NCH - 1;
    for (int c = 0; c < NCH; c++) mq[c] = rq[c];
    build_expected();
    run_done(500);

    // Randomized traffic.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          int nmsg;
          nmsg = $urandom_range(1, 2);
          for (int m = 0; m < nmsg; m++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) push_byte(c, 8'($urandom), i == len - 1);
          end
        end
      end
      build_expected();
      drive_req();
      run_done(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
